// File: rtl/h14tx_pkg.sv
// Shared types and default parameters for the TX PLL reset sequencer.
package h14tx_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_ctrl_state_e;

  localparam int unsigned RESET_CYCLES_DEF  = 16;
  localparam int unsigned LOCK_TIMEOUT_DEF  = 65536;
  localparam int unsigned SETTLE_CYCLES_DEF = 1024;
  localparam int unsigned MAX_RETRIES_DEF   = 7;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/h14tx_pll_ctrl_if.sv
// Control/status bundle between the PLL sequencer (master) and the PLL wrapper/downstream (slave).
interface h14tx_pll_ctrl_if;
  logic       lock;
  logic       restart;
  logic       pll_rst_n;
  logic       timings_rst_n;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  modport master (
    input  lock, restart,
    output pll_rst_n, timings_rst_n, ready, fault, retry_cnt, lock_loss_cnt
  );

  modport slave (
    output lock, restart,
    input  pll_rst_n, timings_rst_n, ready, fault, retry_cnt, lock_loss_cnt
  );
endinterface

// File: rtl/h14tx_sync.sv
// Generic 2-flop synchronizer for asynchronous inputs into the ref_clk domain.
module h14tx_sync #(
  parameter int WIDTH = 1
) (
  input  logic             ref_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/h14tx_pll_ctrl.sv
// TX PLL sequencer: PLL reset, lock wait with timeout, lock qualification, then
// release of the downstream reset. Bounded retries end in a sticky fault.
module h14tx_pll_ctrl
  import h14tx_pkg::*;
#(
  parameter int unsigned ResetCycles  = RESET_CYCLES_DEF,
  parameter int unsigned LockTimeout  = LOCK_TIMEOUT_DEF,
  parameter int unsigned SettleCycles = SETTLE_CYCLES_DEF,
  parameter int unsigned MaxRetries   = MAX_RETRIES_DEF
) (
  input logic              ref_clk,
  input logic              rst_n,
  h14tx_pll_ctrl_if.master bus
);
  localparam int unsigned CNT_MAX = max3(ResetCycles, LockTimeout, SettleCycles);
  localparam int unsigned CW      = $clog2(CNT_MAX);

  pll_ctrl_state_e state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [3:0]      retry, retry_nxt;
  logic [7:0]      lls, lls_nxt;
  logic            lock_s;
  logic            pll_rst_n_q, timings_rst_n_q, ready_q, fault_q;

  h14tx_sync #(.WIDTH(1)) u_lock_sync (
    .ref_clk (ref_clk),
    .rst_n   (rst_n),
    .d       (bus.lock),
    .q       (lock_s)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    retry_nxt = retry;
    lls_nxt   = lls;
    case (state)
      ST_RESET: begin
        if (cnt == CW'(ResetCycles - 1)) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = '0;
        end else if (cnt == CW'(LockTimeout - 1)) begin
          cnt_nxt = '0;
          if (retry == 4'(MaxRetries)) begin
            state_nxt = ST_FAULT;
          end else begin
            state_nxt = ST_RESET;
            retry_nxt = retry + 4'd1;
          end
        end
      end
      ST_SETTLE: begin
        // A dropout here is a lock glitch, not a failed attempt.
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == CW'(SettleCycles - 1)) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        cnt_nxt = '0;
        if (!lock_s) begin
          state_nxt = ST_RESET;
          if (lls != 8'hFF) lls_nxt = lls + 8'd1;
        end
      end
      default: begin
        state_nxt = ST_FAULT;
        cnt_nxt   = '0;
      end
    endcase
    if (bus.restart) begin
      state_nxt = ST_RESET;
      cnt_nxt   = '0;
      retry_nxt = '0;
    end
  end

  // Outputs are registered from the next state so they switch on the entering edge.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_RESET;
      cnt             <= '0;
      retry           <= '0;
      lls             <= '0;
      pll_rst_n_q     <= 1'b0;
      timings_rst_n_q <= 1'b0;
      ready_q         <= 1'b0;
      fault_q         <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      retry           <= retry_nxt;
      lls             <= lls_nxt;
      pll_rst_n_q     <= (state_nxt != ST_RESET) && (state_nxt != ST_FAULT);
      timings_rst_n_q <= (state_nxt == ST_RUN);
      ready_q         <= (state_nxt == ST_RUN);
      fault_q         <= (state_nxt == ST_FAULT);
    end
  end

  assign bus.pll_rst_n     = pll_rst_n_q;
  assign bus.timings_rst_n = timings_rst_n_q;
  assign bus.ready         = ready_q;
  assign bus.fault         = fault_q;
  assign bus.retry_cnt     = retry;
  assign bus.lock_loss_cnt = lls;
endmodule

// File: tb/tb_h14tx_pll_ctrl.sv
// Bench for h14tx_pll_ctrl: directed scenarios with randomized lock timing,
// expectations derived from the dwell-time rules.
module tb_h14tx_pll_ctrl;
  localparam int RC = 4;
  localparam int LT = 32;
  localparam int SC = 8;
  localparam int MR = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   losses = 0;

  h14tx_pll_ctrl_if bus();

  h14tx_pll_ctrl #(
    .ResetCycles (RC),
    .LockTimeout (LT),
    .SettleCycles(SC),
    .MaxRetries  (MR)
  ) dut (
    .ref_clk (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int s);
    case (s)
      0:       return bus.pll_rst_n;
      1:       return bus.ready;
      2:       return bus.timings_rst_n;
      default: return bus.fault;
    endcase
  endfunction

  // Ticks until the selected output equals v; n = ticks taken (bounded).
  task automatic wait_val(input int s, input logic v, input int maxc, output int n);
    n = 0;
    while (sig(s) !== v && n < maxc) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll"},   int'(bus.pll_rst_n), 0);
    chk({tag, "_tim"},   int'(bus.timings_rst_n), 0);
    chk({tag, "_rdy"},   int'(bus.ready), 0);
    chk({tag, "_flt"},   int'(bus.fault), 0);
    chk({tag, "_retry"}, int'(bus.retry_cnt), 0);
    chk({tag, "_lls"},   int'(bus.lock_loss_cnt), 0);
  endtask

  initial begin
    int n, k, g, r, exp_rdy;
    rst_n       = 1'b0;
    bus.lock    = 1'b0;
    bus.restart = 1'b0;
    #2;
    chk_reset_vals("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Clean bring-up: lock 10 cycles after PLL reset release
    wait_val(0, 1'b1, 200, n);
    chk("reset_dwell", n, RC);
    repeat (10) tick();
    bus.lock = 1'b1;
    wait_val(1, 1'b1, 200, n);
    chk("bringup_lat", n, 2 + 1 + SC);
    chk("bringup_tim", int'(bus.timings_rst_n), 1);
    chk("bringup_retry", int'(bus.retry_cnt), 0);
    chk("bringup_pll", int'(bus.pll_rst_n), 1);

    // First lock loss
    bus.lock = 1'b0;
    wait_val(2, 1'b0, 20, n);
    losses++;
    chk("loss_fall", n, 3);
    chk("loss_rdy", int'(bus.ready), 0);
    chk("loss_pll", int'(bus.pll_rst_n), 0);
    chk("loss_lls", int'(bus.lock_loss_cnt), 1);

    // Glitch in SETTLE at a random point, random duration
    wait_val(0, 1'b1, 200, n);
    chk("reseq_dwell", n, RC);
    k = $urandom_range(1, 5);
    g = $urandom_range(1, 4);
    bus.lock = 1'b1;
    repeat (3 + k) tick();
    bus.lock = 1'b0;
    repeat (g) tick();
    chk("glitch_rdy_low", int'(bus.ready), 0);
    bus.lock = 1'b1;
    wait_val(1, 1'b1, 200, n);
    chk("glitch_full_settle", n, 2 + 1 + SC);
    chk("glitch_retry", int'(bus.retry_cnt), 0);

    // 256 more lock losses with random re-lock time; counter saturates
    for (int i = 0; i < 256; i++) begin
      r = $urandom_range(0, 20);
      bus.lock = 1'b0;
      wait_val(2, 1'b0, 20, n);
      losses++;
      chk("sat_fall", n, 3);
      chk("sat_lls", int'(bus.lock_loss_cnt), (losses > 255) ? 255 : losses);
      repeat (r) tick();
      bus.lock = 1'b1;
      // SETTLE starts at max(r+3, RC+1) after RESET entry, RUN SC later
      exp_rdy = ((r + 3 > RC + 1) ? r + 3 : RC + 1) + SC - r;
      wait_val(1, 1'b1, 200, n);
      chk("sat_relock", n, exp_rdy);
    end

    // Timeouts to fault
    bus.lock = 1'b0;
    wait_val(2, 1'b0, 20, n);
    chk("to_fall", n, 3);
    chk("to_lls_sat", int'(bus.lock_loss_cnt), 255);
    for (int a = 0; a <= MR; a++) begin
      wait_val(0, 1'b1, 200, n);
      chk("to_reset_dwell", n, RC);
      wait_val(0, 1'b0, 200, n);
      chk("to_wait_dwell", n, LT);
      chk("to_retry", int'(bus.retry_cnt), (a < MR) ? a + 1 : MR);
      chk("to_fault", int'(bus.fault), (a < MR) ? 0 : 1);
    end
    repeat (50) tick();
    chk("fault_hold", int'(bus.fault), 1);
    chk("fault_pll", int'(bus.pll_rst_n), 0);
    chk("fault_rdy", int'(bus.ready), 0);

    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    chk("rst_fault", int'(bus.fault), 0);
    chk("rst_retry", int'(bus.retry_cnt), 0);
    chk("rst_pll", int'(bus.pll_rst_n), 0);
    wait_val(0, 1'b1, 200, n);
    chk("rst_dwell", n, RC);

    // Restart coincident with the final timeout wins over FAULT
    wait_val(0, 1'b0, 200, n);
    chk("pri_wait1", n, LT);
    wait_val(0, 1'b1, 200, n);
    wait_val(0, 1'b0, 200, n);
    chk("pri_retry2", int'(bus.retry_cnt), 2);
    wait_val(0, 1'b1, 200, n);
    repeat (LT - 1) tick();
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    chk("pri_fault", int'(bus.fault), 0);
    chk("pri_retry", int'(bus.retry_cnt), 0);
    chk("pri_pll", int'(bus.pll_rst_n), 0);
    wait_val(0, 1'b1, 200, n);
    chk("pri_dwell", n, RC);

    // Async reset in the middle of SETTLE
    bus.lock = 1'b1;
    repeat (5) tick();
    chk("pre_ar_pll", int'(bus.pll_rst_n), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    repeat (3) tick();
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/h14tx_pll_ctrl.md
# h14tx_pll_ctrl

Sequences the TX PLL through reset, lock acquisition and lock qualification, then releases the downstream timing/serializer reset. Sits between the board reset and the PLL primitive wrapper: it drives the PLL reset, watches the PLL lock, and supplies the qualified `timings_rst_n`. Recovers automatically from lock-acquisition timeouts and lock loss, with bounded retries and a sticky fault.

## Interface
- `ResetCycles`, 16: cycles `pll_rst_n` is held low per attempt; must be ≥ 1.
- `LockTimeout`, 65536: maximum cycles in WAIT_LOCK before the attempt fails; must be ≥ 2.
- `SettleCycles`, 1024: consecutive cycles synchronized lock must stay high before RUN; must be ≥ 1.
- `MaxRetries`, 7: failed attempts tolerated before FAULT; range 0..15.

Ports:
- `ref_clk` in 1: reference clock; sole clock.
- `rst_n` in 1: reset, asynchronous assert, active-low. This is the already-decided reset: one clock (`ref_clk`), reset asynchronous and active-low.
- `lock` in 1: PLL lock; asynchronous to `ref_clk`.
- `restart` in 1: single-cycle request to re-sequence from scratch.
- `pll_rst_n` out 1: PLL reset, active-low.
- `timings_rst_n` out 1: downstream reset, active-low; high only in RUN.
- `ready` out 1: high in RUN.
- `fault` out 1: high in FAULT.
- `retry_cnt` out 4: failed attempts since the last `restart` or `rst_n`.
- `lock_loss_cnt` out 8: RUN→lock-loss events; saturates at 255; cleared only by `rst_n`.

## Operation
- `lock` passes through a 2-flop synchronizer to produce `lock_s`. All decisions use `lock_s`.
- States are RESET, WAIT_LOCK, SETTLE, RUN and FAULT. After `rst_n` the block is in RESET, and every counter is 0.
- RESET:
  - `pll_rst_n`=0; the phase counter counts up.
  - At count = ResetCycles−1, go to WAIT_LOCK and clear the counter.
- WAIT_LOCK:
  - `pll_rst_n`=1; the counter counts up.
  - If `lock_s`=1, go to SETTLE and clear the counter.
  - Else, at count = LockTimeout−1, the attempt fails.
- SETTLE:
  - The counter counts cycles with `lock_s`=1.
  - If `lock_s`=0, return to WAIT_LOCK with the counter cleared; this is not a failure.
  - At count = SettleCycles−1 with `lock_s`=1, go to RUN.
- RUN:
  - `timings_rst_n`=1 and `ready`=1.
  - If `lock_s`=0, `lock_loss_cnt`++ (saturating) and go to RESET. Lock loss does not consume a retry.
- Attempt failure:
  - If `retry_cnt` = MaxRetries, go to FAULT.
  - Else `retry_cnt`++ and go to RESET.
- FAULT: `pll_rst_n`=0 and `fault`=1. The block stays in FAULT until `restart`.
- `restart`, from any state:
  - Go to RESET, clear the counter and clear `retry_cnt`.
  - `restart` has priority over every other transition in the same cycle.
  - `lock_loss_cnt` is not affected.
- All outputs come straight from flops; there is no combinational path from inputs to outputs.

## Timing
- Reset values: `pll_rst_n`=0, `timings_rst_n`=0, `ready`=0, `fault`=0, `retry_cnt`=0, `lock_loss_cnt`=0, synchronizer=0.
- State dwell times:
  - RESET lasts exactly ResetCycles cycles.
  - A failing WAIT_LOCK lasts exactly LockTimeout cycles.
  - SETTLE lasts exactly SettleCycles cycles when lock is stable.
- Lock rise to SETTLE: `lock_s` rises 2 edges after `lock`; the state becomes SETTLE on the next edge.
- Lock fall in RUN: `timings_rst_n` falls ≤ 3 `ref_clk` edges after `lock` falls (2 synchronizer edges + 1 state edge).
- Output alignment:
  - `pll_rst_n` falls on the same edge that enters RESET.
  - `timings_rst_n` and `ready` rise on the edge entering RUN and fall on the edge leaving it.
- Counter width: ⌈log2(max(ResetCycles, LockTimeout, SettleCycles))⌉. The counter never wraps, because each state clears it on exit.
- Asynchronous `rst_n` assertion mid-sequence forces all reset values immediately.

## Structure
- Package `h14tx_pkg` holds `pll_ctrl_state_e` (the 5 states) and the `h14tx_pll_ctrl` default parameter constants.
- Sub-module `h14tx_sync`: a generic 2-flop synchronizer, with width parameter, `ref_clk`/`rst_n`, reset value 0. It is reused elsewhere for async inputs.
- The control FSM, phase counter and status counters live in `h14tx_pll_ctrl`.

## Test plan
All scenarios use ResetCycles=4, LockTimeout=32, SettleCycles=8, MaxRetries=2.
- Clean bring-up:
  - Stimulus: `lock` rises 10 cycles after `pll_rst_n` rises.
  - Response: `pll_rst_n` low 4 cycles; `timings_rst_n`/`ready` high exactly 2+1+8 cycles after `lock` rises; `retry_cnt`=0.
- Glitch in SETTLE:
  - Stimulus: `lock` drops for 3 cycles after 5 cycles in SETTLE, then returns.
  - Response: return to WAIT_LOCK; the full 8-cycle SETTLE restarts; no retry is counted.
- Timeouts to fault:
  - Stimulus: `lock` held 0.
  - Response: 3 attempts of 4+32 cycles; `retry_cnt` goes 1 then 2; then `fault`=1 with `pll_rst_n`=0 held.
  - Then: `restart` pulse → `retry_cnt`=0 and RESET entered.
- Lock loss in RUN:
  - Stimulus: deassert `lock`.
  - Response: `timings_rst_n`=0 within 3 cycles; `lock_loss_cnt` 0→1; re-sequence reaches RUN again; saturation check after 256 losses reads 255.
- Priority and reset:
  - Stimulus: `restart` in the same cycle as a WAIT_LOCK timeout with `retry_cnt`=2.
  - Response: RESET, not FAULT.
  - Stimulus: async `rst_n` low mid-SETTLE.
  - Response: all outputs reach reset values without a clock edge.
